// File: rtl/twotoone_mux_arb_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
package twotoone_mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/twotoone_mux_nand_behav_using_always.sv
// 2:1 mux built from NAND terms, described behaviourally; S=0 selects A, S=1 selects B.
module twotoone_mux_nand_behav_using_always (
    input  logic S,
    input  logic A,
    input  logic B,
    output logic Z
);

    logic nandA;
    logic nandB;

    always_comb begin
        nandA = ~(A & ~S);
        nandB = ~(B & S);
        Z     = ~(nandA & nandB);
    end

endmodule

// File: rtl/twotoone_mux_arbiter.sv
// Round-robin arbiter that owns the select of a shared 2:1 mux and registers
// the selected bit onto Z with a VALID qualifier.
module twotoone_mux_arbiter
    import twotoone_mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic REQ_A,
    input  logic REQ_B,
    input  logic A,
    input  logic B,
    output logic GNT_A,
    output logic GNT_B,
    output logic S,
    output logic Z,
    output logic VALID
);

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lastB_q, lastB_d;
    logic             sel_q, sel_d;
    logic             z_q;
    logic             valid_q;
    logic             muxZ;
    logic             ownReq;
    logic             otherReq;

    twotoone_mux_nand_behav_using_always u_mux (
        .S (sel_q),
        .A (A),
        .B (B),
        .Z (muxZ)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lastB_d  = lastB_q;
        sel_d    = sel_q;
        ownReq   = (state_q == OWN_A) ? REQ_A : REQ_B;
        otherReq = (state_q == OWN_A) ? REQ_B : REQ_A;

        case (state_q)
            IDLE: begin
                if (REQ_A && REQ_B)
                    state_d = lastB_q ? OWN_A : OWN_B;
                else if (REQ_A)
                    state_d = OWN_A;
                else if (REQ_B)
                    state_d = OWN_B;
            end
            OWN_A, OWN_B: begin
                // The counter only measures how long the other side has been kept waiting.
                if (ownReq && !(otherReq && (cnt_q == HOLD_LIMIT)))
                    cnt_d = otherReq ? cnt_q + CNT_W'(1) : '0;
                else if (otherReq)
                    state_d = (state_q == OWN_A) ? OWN_B : OWN_A;
                else
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if ((state_d != state_q) && (state_d != IDLE)) begin
            cnt_d   = '0;
            lastB_d = (state_d == OWN_B);
            sel_d   = (state_d == OWN_B) ? SEL_B : SEL_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lastB_q <= 1'b1;
            sel_q   <= SEL_A;
            z_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lastB_q <= lastB_d;
            sel_q   <= sel_d;
            z_q     <= muxZ;
            valid_q <= GNT_A | GNT_B;
        end
    end

    assign GNT_A = (state_q == OWN_A);
    assign GNT_B = (state_q == OWN_B);
    assign S     = sel_q;
    assign Z     = z_q;
    assign VALID = valid_q;

endmodule

// File: tb/tb_twotoone_mux_arbiter.sv
// Self-checking bench for twotoone_mux_arbiter against a grant-ownership reference model.
module tb_twotoone_mux_arbiter;

    localparam int MAX_HOLD = 8;

    logic clk;
    logic rst_n;
    logic reqA, reqB, dataA, dataB;
    logic GNT_A, GNT_B, S, Z, VALID;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: owner 0 = nobody, 1 = A, 2 = B.
    int   mOwner;
    int   mWaitRun;
    int   mLast;
    logic mS, mZ, mValid;

    twotoone_mux_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .REQ_A (reqA),
        .REQ_B (reqB),
        .A     (dataA),
        .B     (dataB),
        .GNT_A (GNT_A),
        .GNT_B (GNT_B),
        .S     (S),
        .Z     (Z),
        .VALID (VALID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        mOwner   = 0;
        mWaitRun = 0;
        mLast    = 2;
        mS       = 1'b0;
        mZ       = 1'b0;
        mValid   = 1'b0;
    endtask

    task automatic modelEdge();
        int   prevOwner;
        logic mine, other;
        prevOwner = mOwner;
        mZ        = mS ? dataB : dataA;
        mValid    = (mOwner != 0);
        if (mOwner == 0) begin
            if (reqA && reqB)      mOwner = (mLast == 1) ? 2 : 1;
            else if (reqA)         mOwner = 1;
            else if (reqB)         mOwner = 2;
        end else begin
            mine  = (mOwner == 1) ? reqA : reqB;
            other = (mOwner == 1) ? reqB : reqA;
            if (mine && !(other && mWaitRun == MAX_HOLD - 1))
                mWaitRun = other ? mWaitRun + 1 : 0;
            else if (other)
                mOwner = 3 - mOwner;
            else
                mOwner = 0;
        end
        if (mOwner != prevOwner && mOwner != 0) begin
            mWaitRun = 0;
            mLast    = mOwner;
            mS       = (mOwner == 2);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
    endtask

    task automatic checkOutput();
        checkBit("GNT_A", GNT_A, logic'(mOwner == 1));
        checkBit("GNT_B", GNT_B, logic'(mOwner == 2));
        checkBit("S", S, mS);
        checkBit("Z", Z, mZ);
        checkBit("VALID", VALID, mValid);
        checkBit("GNT_EXCL", GNT_A & GNT_B, 1'b0);
    endtask

    // Called at a negedge; drives inputs, lets one rising edge pass, checks, returns at the next negedge.
    task automatic applyStimulus(input logic ra, input logic rb, input logic a, input logic b);
        reqA  = ra;
        reqB  = rb;
        dataA = a;
        dataB = b;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    task automatic applyReset();
        #2;
        rst_n = 1'b0;
        reqA  = 1'($urandom_range(0, 1));
        reqB  = 1'($urandom_range(0, 1));
        dataA = 1'($urandom_range(0, 1));
        dataB = 1'($urandom_range(0, 1));
        modelReset();
        #1;
        checkOutput();
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput();
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        reqA  = 1'b0;
        reqB  = 1'b0;
        dataA = 1'b1;
        dataB = 1'b1;
        #1;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset with A held low so Z stays 0.
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));

        // Single requester B with data 1, then release.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkBit("SINGLE_GNT_B", GNT_B, 1'b1);
        checkBit("SINGLE_S", S, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkBit("SINGLE_Z", Z, 1'b1);
        checkBit("SINGLE_VALID", VALID, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkBit("RELEASE_GNT_B", GNT_B, 1'b0);
        checkBit("RELEASE_VALID", VALID, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Tie straight from reset, then A hands over to B with no gap.
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkBit("TIE_A_FIRST", GNT_A, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkBit("HANDOVER_B", GNT_B, 1'b1);
        checkBit("HANDOVER_A_OFF", GNT_A, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Continuous contention: blocks of MAX_HOLD grants alternating A, B.
        applyReset();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checkBit("FAIR_A", GNT_A, logic'(((i / MAX_HOLD) % 2) == 0));
            checkBit("FAIR_B", GNT_B, logic'(((i / MAX_HOLD) % 2) == 1));
        end

        // Data steering: B granted with B=0 while A toggles, then swap to A.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'(i % 2), 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'(i % 2), 1'b0);

        // Reset mid-grant with B owning and counter at 5.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkBit("PRE_RST_GNT_B", GNT_B, 1'b1);
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkBit("POST_RST_TIE_A", GNT_A, 1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0)
                applyReset();
            else
                applyStimulus(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/twotoone_mux_arbiter.md
# twotoone_mux_arbiter

Round-robin arbiter and sequencer that shares one 2:1 NAND mux datapath between two requesters, A and B. It accepts requests on `REQ_A` and `REQ_B` and issues one-hot grants. It drives the mux select `S` and registers the selected data bit onto `Z` with a `VALID` qualifier. It sits directly in front of `twotoone_mux_nand_behav_using_always` and is the only agent that drives that mux's `S` input.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester keeps the grant while the other is waiting. Legal range 2..2^CNT_W.
- `CNT_W`, default 4: width of the hold counter.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset, asynchronous assert and active-low.
- `REQ_A` input 1: requester A wants the mux. Level-sensitive; held for as long as access is wanted.
- `REQ_B` input 1: requester B wants the mux. Same rules as `REQ_A`.
- `A` input 1: data bit from requester A.
- `B` input 1: data bit from requester B.
- `GNT_A` output 1: grant to A. Registered.
- `GNT_B` output 1: grant to B. Registered. `GNT_A` and `GNT_B` are never both 1.
- `S` output 1: mux select. 0 selects `A`, 1 selects `B`. Registered.
- `Z` output 1: registered mux output.
- `VALID` output 1: `Z` carries granted data this cycle.

## Operation
- **States:** IDLE, OWN_A, OWN_B.
- **Reset values:**
  - state = IDLE.
  - `GNT_A` = `GNT_B` = 0, `S` = 0, `Z` = 0, `VALID` = 0.
  - hold counter = 0.
  - last-owner pointer = B, so A wins the first tie.
- **IDLE:**
  - Only `REQ_A` asserted: go to OWN_A.
  - Only `REQ_B` asserted: go to OWN_B.
  - Both asserted: grant the requester that is not the last owner.
  - Neither asserted: stay in IDLE. `S` keeps its previous value.
- **OWN_X** (X = A or B; Y is the other requester):
  - `REQ_X` high and (`REQ_Y` low, or counter < MAX_HOLD-1): stay. Counter increments while `REQ_Y` is high; it holds at 0 while `REQ_Y` is low.
  - `REQ_X` high, `REQ_Y` high, counter = MAX_HOLD-1: forced preemption. Go directly to OWN_Y.
  - `REQ_X` low and `REQ_Y` high: go directly to OWN_Y, with no IDLE cycle.
  - `REQ_X` low and `REQ_Y` low: go to IDLE.
- **Entering OWN_X:** counter clears to 0, last-owner pointer is set to X, and `S` is set to X's select value.
- **Outputs:**
  - `GNT_A` = (state == OWN_A).
  - `GNT_B` = (state == OWN_B).
- **Datapath, every cycle:**
  - `Z` <= the mux output for the current `S`, `A`, `B`.
  - `VALID` <= `GNT_A | GNT_B`.
  - When `VALID` is 0, `Z` still updates; consumers ignore it.
- **Counter arithmetic:** unsigned, `CNT_W` bits. It never wraps, because the compare at MAX_HOLD-1 forces a state change first.

## Timing
- Request latency:
  - `REQ_X` rises before edge n.
  - `GNT_X` and `S` are valid after edge n.
  - `Z` and `VALID` are valid after edge n+1.
  - Request-to-data latency is 2 cycles.
- Handover (release or preemption):
  - Old grant drops and new grant rises on the same edge.
  - There is no cycle with both grants high.
  - There is no idle gap when the other requester is waiting.
- Fairness: under continuous contention, grants alternate A and B in blocks of exactly MAX_HOLD cycles each.
- Release: a requester deasserting `REQ_X` loses its grant on the next edge. Data sampled on that edge is still flagged `VALID`.
- Reset mid-operation:
  - All outputs go to their reset values immediately on `rst_n` falling, without waiting for a clock edge.
  - After `rst_n` rises, the first active edge behaves as from IDLE.

## Structure
- Shared package `twotoone_mux_arb_pkg` holds:
  - the state enum (IDLE, OWN_A, OWN_B);
  - localparams `SEL_A` = 0 and `SEL_B` = 1;
  - the default MAX_HOLD value.
- One sub-module: instantiate the existing `twotoone_mux_nand_behav_using_always` (ports `S`, `A`, `B`, `Z`) as the combinational datapath. Its `Z` feeds the output register.
- The FSM, hold counter, last-owner pointer and output registers live in the top module.

## Test plan
- **Reset:** `rst_n` = 0 with random inputs → `GNT_A` = `GNT_B` = `S` = `Z` = `VALID` = 0 immediately. Release `rst_n`, with no requests → remains IDLE with all outputs 0.
- **Single requester:** `REQ_B` = 1, `B` = 1 at edge n → `GNT_B` = 1 and `S` = 1 after edge n; `Z` = 1 and `VALID` = 1 after edge n+1. Drop `REQ_B` → `GNT_B` = 0 next edge and state returns to IDLE.
- **Tie from reset:** `REQ_A` = `REQ_B` = 1 on the same edge → A granted first. A releases → B granted on the same edge A drops, with no gap.
- **Forced preemption:** MAX_HOLD = 8, both requests held for 40 cycles → grant pattern A×8, B×8, A×8, B×8, A×8. Grants are never simultaneous.
- **Data steering:** with B granted, toggle `A` every cycle while `B` = 0 → `Z` stays 0. Swap to an A grant → `Z` follows `A` with 1-cycle lag.
- **Reset mid-grant:** assert `rst_n` = 0 during OWN_B at counter = 5 → outputs clear asynchronously. After release, with both requesting, A is granted first because the pointer was reset.
